// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Wait-stated data memory for a CPU Memory stage. A read or write request is
//   held off for WAIT cycles (MemStall high), then committed against an
//   internal 2^ADDR_W x 16-bit RAM. Accesses whose address has any bit set
//   above the RAM range are flagged with a one-cycle Err pulse; such writes
//   are dropped and such reads return zero.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset (RAM contents survive it)
//   MemRd    in   read request
//   MemWr    in   write request (wins when both are high)
//   Addr     in   16-bit word address
//   DataIn   in   16-bit store data
//   MemOut   out  registered read data, held until the next committed read
//   MemStall out  combinational stall; the CPU freezes while it is high
//   Err      out  registered one-cycle out-of-range pulse after the commit
module data_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] MemOut,
  output logic        MemStall,
  output logic        Err
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] BUSY    = 1'b1;
  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [2:0] WAIT_M1 = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  logic [0:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [15:0] mem_out_q, mem_out_d;
  logic        err_q, err_d;

  logic [15:0] ram [DEPTH];

  logic              commit;
  logic [15:0]       c_addr;
  logic [15:0]       c_data;
  logic              c_wr;
  logic              c_oor;
  logic [ADDR_W-1:0] c_idx;
  logic              ram_we;

  // Stage 0: request sequencing and selection of the access to commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    MemStall = 1'b0;
    commit   = 1'b0;
    c_addr   = addr_q;
    c_data   = data_q;
    c_wr     = wr_q;

    case (state_q)
      IDLE: begin
        if (MemRd || MemWr) begin
          if (WAIT == 0) begin
            // Zero-wait configuration commits straight from the live inputs.
            commit = 1'b1;
            c_addr = Addr;
            c_data = DataIn;
            c_wr   = MemWr;
          end else begin
            addr_d   = Addr;
            data_d   = DataIn;
            wr_d     = MemWr;
            cnt_d    = WAIT_M1;
            state_d  = BUSY;
            MemStall = 1'b1;
          end
        end
      end
      BUSY: begin
        // Inputs are deliberately ignored here; the latched request commits.
        if (cnt_q != 3'd0) begin
          MemStall = 1'b1;
          cnt_d    = cnt_q - 3'd1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    c_oor  = (c_addr >> ADDR_W) != 16'd0;
    c_idx  = c_addr[ADDR_W-1:0];
    // Reset aborts an in-flight access, so the RAM write is gated by rst too.
    ram_we = commit && c_wr && !c_oor && !rst;

    mem_out_d = mem_out_q;
    if (commit && !c_wr) begin
      mem_out_d = c_oor ? 16'h0000 : ram[c_idx];
    end
    err_d = commit && c_oor;
  end

  // Stage 1: registered state, read data and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      mem_out_q <= 16'h0000;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_out_q <= mem_out_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    wr_q   <= wr_d;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[c_idx] <= c_data;
    end
  end

  assign MemOut = mem_out_q;
  assign Err    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_i  [3];
  logic        rd_i   [3];
  logic        wr_i   [3];
  logic [15:0] addr_i [3];
  logic [15:0] din_i  [3];
  logic [15:0] mout   [3];
  logic        stall  [3];
  logic        err    [3];

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;
  int wt [3] = '{2, 0, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_W(10), .WAIT(2)) u0 (
    .clk(clk), .rst(rst_i[0]), .MemRd(rd_i[0]), .MemWr(wr_i[0]), .Addr(addr_i[0]),
    .DataIn(din_i[0]), .MemOut(mout[0]), .MemStall(stall[0]), .Err(err[0]));
  data_mem_responder #(.ADDR_W(10), .WAIT(0)) u1 (
    .clk(clk), .rst(rst_i[1]), .MemRd(rd_i[1]), .MemWr(wr_i[1]), .Addr(addr_i[1]),
    .DataIn(din_i[1]), .MemOut(mout[1]), .MemStall(stall[1]), .Err(err[1]));
  data_mem_responder #(.ADDR_W(10), .WAIT(3)) u2 (
    .clk(clk), .rst(rst_i[2]), .MemRd(rd_i[2]), .MemWr(wr_i[2]), .Addr(addr_i[2]),
    .DataIn(din_i[2]), .MemOut(mout[2]), .MemStall(stall[2]), .Err(err[2]));

  task automatic chk16(string nm, logic [15:0] act, logic [15:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a request first seen at cycle t0 stalls
  // while (cyc - t0) < WAIT and commits at the end of cycle t0 + WAIT.
  bit          act   [3];
  int          t0    [3];
  bit          m_wr  [3];
  logic [15:0] m_a   [3];
  logic [15:0] m_d   [3];
  logic [15:0] e_out [3] = '{16'h0, 16'h0, 16'h0};
  bit          e_err [3];
  logic [15:0] mram  [3][1024];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        bit es;
        if (!act[d] && (rd_i[d] || wr_i[d])) begin
          act[d]  = 1'b1;
          t0[d]   = cyc;
          m_wr[d] = wr_i[d];
          m_a[d]  = addr_i[d];
          m_d[d]  = din_i[d];
        end
        es = act[d] && ((cyc - t0[d]) < wt[d]);
        chk1($sformatf("stall[%0d] cyc%0d", d, cyc), stall[d], es);
        chk16($sformatf("memout[%0d] cyc%0d", d, cyc), mout[d], e_out[d]);
        chk1($sformatf("err[%0d] cyc%0d", d, cyc), err[d], e_err[d]);
        e_err[d] = 1'b0;
        if (rst_i[d]) begin
          act[d]   = 1'b0;
          e_out[d] = 16'h0000;
        end else if (act[d] && (cyc - t0[d]) == wt[d]) begin
          act[d] = 1'b0;
          if (m_a[d] >= 16'd1024) e_err[d] = 1'b1;
          if (m_wr[d]) begin
            if (m_a[d] < 16'd1024) mram[d][m_a[d][9:0]] = m_d[d];
          end else begin
            e_out[d] = (m_a[d] < 16'd1024) ? mram[d][m_a[d][9:0]] : 16'h0000;
          end
        end
      end
    end
  end

  task automatic drive(int d, logic r, logic w, logic [15:0] a, logic [15:0] di);
    rd_i[d]   = r;
    wr_i[d]   = w;
    addr_i[d] = a;
    din_i[d]  = di;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the commit edge; returns #1 after it.
  task automatic access(int d, logic r, logic w, logic [15:0] a, logic [15:0] di);
    int n = 0;
    drive(d, r, w, a, di);
    @(negedge clk);
    while (stall[d]) begin
      n++;
      if (n > 20) begin
        vec++;
        miss++;
        $display("FAIL access[%0d] timeout: stall still %b after %0d cycles, expected 0", d, stall[d], n);
        break;
      end
      @(negedge clk);
    end
    step();
    drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_i[d] = 1'b1;
      drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    @(posedge clk);
    chk_en = 1'b1;
    step();
    for (int d = 0; d < 3; d++) rst_i[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk16($sformatf("reset memout[%0d]", d), mout[d], 16'h0000);
      chk1($sformatf("reset stall[%0d]", d), stall[d], 1'b0);
      chk1($sformatf("reset err[%0d]", d), err[d], 1'b0);
    end
    step();

    // WAIT=2: write then read back
    access(0, 1'b0, 1'b1, 16'h0005, 16'h1234);
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    chk16("wait2 readback", mout[0], 16'h1234);

    // WAIT=0: top in-range word, consecutive accesses
    access(1, 1'b0, 1'b1, 16'h03FF, 16'h0001);
    access(1, 1'b1, 1'b0, 16'h03FF, 16'h0000);
    chk16("wait0 first read", mout[1], 16'h0001);
    access(1, 1'b0, 1'b1, 16'h03FF, 16'hBEEF);
    access(1, 1'b1, 1'b0, 16'h03FF, 16'h0000);
    chk16("wait0 second read", mout[1], 16'hBEEF);

    // Out-of-range: write discarded, read returns zero with one Err pulse
    access(0, 1'b0, 1'b1, 16'h0000, 16'h7777);
    access(0, 1'b0, 1'b1, 16'h0400, 16'h0000);
    access(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk16("ram0 before oor read", mout[0], 16'h7777);
    access(0, 1'b1, 1'b0, 16'h0400, 16'h0000);
    chk16("oor read data", mout[0], 16'h0000);
    chk1("oor err pulse", err[0], 1'b1);
    step();
    chk1("oor err cleared", err[0], 1'b0);
    access(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    chk16("ram0 kept", mout[0], 16'h7777);

    // WAIT=3: reset during the second stall cycle aborts the write
    access(2, 1'b0, 1'b1, 16'h0010, 16'h1111);
    drive(2, 1'b0, 1'b1, 16'h0010, 16'hAAAA);
    step();
    rst_i[2] = 1'b1;
    drive(2, 1'b0, 1'b0, 16'h0, 16'h0);
    step();
    rst_i[2] = 1'b0;
    chk1("stall after rst", stall[2], 1'b0);
    chk16("memout after rst", mout[2], 16'h0000);
    access(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk16("aborted write", mout[2], 16'h1111);

    // Read and write together behave as a write
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    access(0, 1'b1, 1'b1, 16'h0001, 16'h5555);
    chk16("rd+wr memout held", mout[0], 16'h1234);
    access(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
    chk16("rd+wr stored", mout[0], 16'h5555);

    // Inputs changed while busy are ignored
    access(0, 1'b0, 1'b1, 16'h0003, 16'h0BAD);
    drive(0, 1'b0, 1'b1, 16'h0002, 16'h3333);
    step();
    drive(0, 1'b0, 1'b1, 16'h0003, 16'h9999);
    step();
    step();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    access(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
    chk16("latched write data", mout[0], 16'h3333);
    access(0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    chk16("untouched word", mout[0], 16'h0BAD);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
